// File: rtl/sfifo_ctrl_pkg.sv
// Shared sizing and write-FSM encodings for the FFT inter-pass FIFO controller.
`ifndef FIFO_ADD_WIDTH
`define FIFO_ADD_WIDTH 3
`endif
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif

package sfifo_ctrl_pkg;
  localparam int FIFO_AW    = `FIFO_ADD_WIDTH;
  localparam int FIFO_DW    = `FFT_DATA_WIDTH;
  localparam int FIFO_DEPTH = 1 << FIFO_AW;

  localparam logic ENC_W_IDLE = 1'b0;
  localparam logic ENC_W_STRB = 1'b1;

  typedef enum logic {
    W_IDLE = ENC_W_IDLE,
    W_STRB = ENC_W_STRB
  } wr_state_e;
endpackage

// File: rtl/sfifo_ctrl_if.sv
// Push/pop stream side of the FIFO controller, with status and error flags.
interface sfifo_ctrl_if
  import sfifo_ctrl_pkg::*;
#(
  parameter int AW = FIFO_AW,
  parameter int DW = FIFO_DW
);
  logic          flush;
  logic          push;
  logic [DW-1:0] push_data;
  logic          pop;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          err_ovf;
  logic          err_udf;

  modport master (
    output flush, push, push_data, pop,
    input  pop_data, pop_valid, full, empty, level, err_ovf, err_udf
  );

  modport slave (
    input  flush, push, push_data, pop,
    output pop_data, pop_valid, full, empty, level, err_ovf, err_udf
  );
endinterface

// File: rtl/sfifo_ptr.sv
// Wrapping AW-bit RAM pointer with synchronous clear and increment.
module sfifo_ptr #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  // Clear wins over increment; natural overflow wraps DEPTH-1 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + AW'(1);
  end
endmodule

// File: rtl/sfifo_ctrl.sv
// FIFO controller for the dual-port RAM_SFifo: port 0 writes, port 1 reads.
// A word is counted in wr_cnt as soon as its push is accepted (drives full),
// but only in level once its write strobe has completed (drives empty).
module sfifo_ctrl
  import sfifo_ctrl_pkg::*;
#(
  parameter int AW    = FIFO_AW,
  parameter int DW    = FIFO_DW,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst_n,
  sfifo_ctrl_if.slave   bus,
  output logic [AW-1:0] ram_addr_0,
  inout  wire  [DW-1:0] ram_data_0,
  output logic          ram_cs_0,
  output logic          ram_we_0,
  output logic          ram_oe_0,
  output logic [AW-1:0] ram_addr_1,
  inout  wire  [DW-1:0] ram_data_1,
  output logic          ram_cs_1,
  output logic          ram_we_1,
  output logic          ram_oe_1
);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  wr_state_e     wstate;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   wr_cnt, wr_cnt_nxt;
  logic [AW:0]   level, level_nxt;
  logic          push_acc, pop_acc, commit;
  logic          full_q, empty_q, pop_valid_q, err_ovf_q, err_udf_q;
  logic [DW-1:0] pop_data_q;
  logic          port1_en;

  // Accept decisions and next-state counts; flush blocks both sides.
  always_comb begin
    push_acc   = bus.push && !full_q  && !bus.flush;
    pop_acc    = bus.pop  && !empty_q && !bus.flush;
    commit     = (wstate == W_STRB);
    wr_cnt_nxt = wr_cnt;
    if (push_acc && !pop_acc)      wr_cnt_nxt = wr_cnt + (AW+1)'(1);
    else if (pop_acc && !push_acc) wr_cnt_nxt = wr_cnt - (AW+1)'(1);
    level_nxt  = level + (AW+1)'(commit) - (AW+1)'(pop_acc);
  end

  sfifo_ptr #(.AW(AW)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush), .inc(push_acc), .ptr(wr_ptr)
  );

  sfifo_ptr #(.AW(AW)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush), .inc(pop_acc), .ptr(rd_ptr)
  );

  // Write strobe FSM: each accepted push holds cs/we for exactly one cycle,
  // back-to-back pushes keep it high while address and data advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate     <= W_IDLE;
      ram_addr_0 <= '0;
      wdata_q    <= '0;
      ram_cs_0   <= 1'b0;
      ram_we_0   <= 1'b0;
    end else if (bus.flush) begin
      wstate   <= W_IDLE;
      ram_cs_0 <= 1'b0;
      ram_we_0 <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE, W_STRB: begin
          if (push_acc) begin
            ram_addr_0 <= wr_ptr;
            wdata_q    <= bus.push_data;
            ram_cs_0   <= 1'b1;
            ram_we_0   <= 1'b1;
            wstate     <= W_STRB;
          end else begin
            ram_cs_0 <= 1'b0;
            ram_we_0 <= 1'b0;
            wstate   <= W_IDLE;
          end
        end
        default: begin
          ram_cs_0 <= 1'b0;
          ram_we_0 <= 1'b0;
          wstate   <= W_IDLE;
        end
      endcase
    end
  end

  // Occupancy, status flags, read capture and sticky misuse flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt      <= '0;
      level       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
    end else if (bus.flush) begin
      wr_cnt      <= '0;
      level       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      pop_valid_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
    end else begin
      wr_cnt      <= wr_cnt_nxt;
      level       <= level_nxt;
      full_q      <= (wr_cnt_nxt == DEPTH_V);
      empty_q     <= (level_nxt == '0);
      pop_valid_q <= pop_acc;
      if (pop_acc)              pop_data_q <= ram_data_1;
      if (bus.push && full_q)   err_ovf_q  <= 1'b1;
      if (bus.pop  && empty_q)  err_udf_q  <= 1'b1;
    end
  end

  // Read port is permanently selected once out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) port1_en <= 1'b0;
    else        port1_en <= 1'b1;
  end

  assign ram_data_0    = ram_we_0 ? wdata_q : {DW{1'bz}};
  assign ram_oe_0      = 1'b0;
  assign ram_addr_1    = rd_ptr;
  assign ram_cs_1      = port1_en;
  assign ram_oe_1      = port1_en;
  assign ram_we_1      = 1'b0;

  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.level     = level;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_udf   = err_udf_q;
endmodule
